// File: rtl/bcd_cook_timer.sv
// Microwave cook-time countdown: four BCD digits entered from the keypad (MM:SS),
// decremented once per second while the magnetron is on.
module bcd_cook_timer #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned CNT_W    = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clearn,
   input  logic       enable,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       timer_done,
   output logic       sec_tick
);

   localparam logic [CNT_W-1:0] TickMax = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] presc_q, presc_d;
   logic [3:0]       mt_d, mu_d, st_d, su_d;
   logic [3:0]       dec_mt, dec_mu, dec_st, dec_su;
   logic             tick_d;
   logic             counting;

   assign timer_done = ~|{min_tens, min_units, sec_tens, sec_units};
   assign counting   = enable && !timer_done;

   // One-second BCD decrement; only used while the time is nonzero.
   always_comb begin
      dec_mt = min_tens;
      dec_mu = min_units;
      dec_st = sec_tens;
      dec_su = sec_units;
      if (sec_units != 4'd0) begin
         dec_su = sec_units - 4'd1;
      end else if (sec_tens != 4'd0) begin
         dec_st = sec_tens - 4'd1;
         dec_su = 4'd9;
      end else begin
         dec_st = 4'd5;
         dec_su = 4'd9;
         if (min_units != 4'd0) begin
            dec_mu = min_units - 4'd1;
         end else begin
            dec_mt = min_tens - 4'd1;
            dec_mu = 4'd9;
         end
      end
   end

   always_comb begin
      mt_d    = min_tens;
      mu_d    = min_units;
      st_d    = sec_tens;
      su_d    = sec_units;
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (!clearn) begin
         mt_d    = 4'd0;
         mu_d    = 4'd0;
         st_d    = 4'd0;
         su_d    = 4'd0;
         presc_d = '0;
      end else if (counting) begin
         if (presc_q == TickMax) begin
            presc_d = '0;
            tick_d  = 1'b1;
            mt_d    = dec_mt;
            mu_d    = dec_mu;
            st_d    = dec_st;
            su_d    = dec_su;
         end else begin
            presc_d = presc_q + CNT_W'(1);
         end
      end else if (!enable && digit_valid && (digit <= 4'd9)) begin
         mt_d = min_units;
         mu_d = sec_tens;
         st_d = sec_units;
         su_d = digit;
      end
      // A time of 00:00 never carries a partial second, however it was reached.
      if ({mt_d, mu_d, st_d, su_d} == 16'h0000) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         min_tens  <= 4'd0;
         min_units <= 4'd0;
         sec_tens  <= 4'd0;
         sec_units <= 4'd0;
         presc_q   <= '0;
         sec_tick  <= 1'b0;
      end else begin
         min_tens  <= mt_d;
         min_units <= mu_d;
         sec_tens  <= st_d;
         sec_units <= su_d;
         presc_q   <= presc_d;
         sec_tick  <= tick_d;
      end
   end

endmodule

// File: tb/tb_bcd_cook_timer.sv
// Directed bench for bcd_cook_timer with a four-cycle second.
module tb_bcd_cook_timer;

   logic       clk = 1'b0;
   logic       reset, clearn, enable, digit_valid;
   logic [3:0] digit;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       timer_done, sec_tick;
   int         n_cmp = 0;
   int         n_err = 0;

   bcd_cook_timer #(.TICK_DIV(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .clearn(clearn), .enable(enable),
      .digit_valid(digit_valid), .digit(digit),
      .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
      .sec_units(sec_units), .timer_done(timer_done), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [15:0] t, input logic tick);
      chk({tag, " time"}, {min_tens, min_units, sec_tens, sec_units}, t);
      chk({tag, " tick"}, {15'd0, sec_tick}, {15'd0, tick});
      chk({tag, " done"}, {15'd0, timer_done}, {15'd0, (t == 16'h0000)});
   endtask

   task automatic key(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      cyc(1);
      digit_valid = 1'b0;
   endtask

   task automatic keys4(input logic [15:0] v);
      key(v[15:12]);
      key(v[11:8]);
      key(v[7:4]);
      key(v[3:0]);
   endtask

   task automatic load(input logic [15:0] v);
      clearn = 1'b0;
      cyc(1);
      clearn = 1'b1;
      keys4(v);
   endtask

   task automatic one_tick(input string tag, input logic [15:0] v, input logic [15:0] nxt);
      load(v);
      enable = 1'b1;
      cyc(3);
      chk_state({tag, " pre"}, v, 1'b0);
      cyc(1);
      enable = 1'b0;
      chk_state({tag, " post"}, nxt, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clearn = 1'b1; enable = 1'b0; digit_valid = 1'b0; digit = 4'd0;
      cyc(2);
      reset = 1'b0;
      chk_state("reset", 16'h0000, 1'b0);

      // Enabled at 00:00: nothing happens.
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("idle tick", {15'd0, sec_tick}, 16'd0);
      end
      chk_state("idle", 16'h0000, 1'b0);
      enable = 1'b0;

      // Entry, with an out-of-range key ignored.
      key(4'd1);
      chk_state("entry 1", 16'h0001, 1'b0);
      key(4'd3);
      key(4'hA);
      chk_state("entry A", 16'h0013, 1'b0);
      key(4'd0);
      chk_state("entry 0130", 16'h0130, 1'b0);
      key(4'd5); key(4'd5); key(4'd5); key(4'd5); key(4'd7);
      chk_state("entry 5557", 16'h5557, 1'b0);

      // Count down to zero and stay there.
      load(16'h0002);
      enable = 1'b1;
      cyc(3);
      chk_state("run c3", 16'h0002, 1'b0);
      cyc(1);
      chk_state("run c4", 16'h0001, 1'b1);
      cyc(3);
      chk_state("run c7", 16'h0001, 1'b0);
      cyc(1);
      chk_state("run c8", 16'h0000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         chk("hold tick", {15'd0, sec_tick}, 16'd0);
      end
      chk_state("hold", 16'h0000, 1'b0);
      enable = 1'b0;

      one_tick("b0100", 16'h0100, 16'h0059);
      one_tick("b1000", 16'h1000, 16'h0959);
      one_tick("b0090", 16'h0090, 16'h0089);
      one_tick("b0010", 16'h0010, 16'h0009);
      one_tick("b9999", 16'h9999, 16'h9998);
      one_tick("b9900", 16'h9900, 16'h9859);

      // Pause keeps the partial second; keys ignored while running.
      load(16'h0005);
      enable = 1'b1;
      cyc(1);
      digit_valid = 1'b1; digit = 4'd7;
      cyc(1);
      digit_valid = 1'b0;
      enable = 1'b0;
      cyc(5);
      chk_state("paused", 16'h0005, 1'b0);
      enable = 1'b1;
      cyc(1);
      chk_state("resume 1", 16'h0005, 1'b0);
      cyc(1);
      chk_state("resume 2", 16'h0004, 1'b1);
      enable = 1'b0;
      key(4'd7);
      chk_state("paused key", 16'h0047, 1'b0);

      // Clear mid-count overrides enable.
      load(16'h1234);
      enable = 1'b1;
      cyc(6);
      chk_state("run 1234", 16'h1233, 1'b0);
      clearn = 1'b0;
      cyc(1);
      clearn = 1'b1;
      enable = 1'b0;
      chk_state("clear", 16'h0000, 1'b0);

      // Reset mid-count discards the partial second.
      load(16'h0003);
      enable = 1'b1;
      cyc(3);
      chk_state("pre reset", 16'h0003, 1'b0);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      enable = 1'b0;
      chk_state("mid reset", 16'h0000, 1'b0);
      keys4(16'h0003);
      enable = 1'b1;
      cyc(3);
      chk_state("after reset c3", 16'h0003, 1'b0);
      cyc(1);
      chk_state("after reset c4", 16'h0002, 1'b1);
      enable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_cook_timer.md
Name: bcd_cook_timer

Overview:
- Cook-time countdown stage of the microwave: holds the MM:SS time entered from the keypad in four BCD digits.
- Counts the time down once per second while the magnetron is on.
- Drives timer_done straight into the magnetron control block and feeds the digits to the display.
- The magnetron output Q is the enable input of this block; timer_done is its primary output.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per second of cook time (must be >= 2; benches use 4)
- CNT_W, 26, prescaler width (must satisfy 2^CNT_W >= TICK_DIV)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high; returns block to 00:00
- clearn  input  1  keypad clear, active-low, sampled on clk
- enable  input  1  magnetron on (Q of magnetron control); counting allowed when 1
- digit_valid  input  1  one-cycle strobe: digit holds a keypad key
- digit  input  4  keypad key code, valid 0-9
- min_tens  output  4  BCD minutes tens
- min_units  output  4  BCD minutes units
- sec_tens  output  4  BCD seconds tens
- sec_units  output  4  BCD seconds units
- timer_done  output  1  1 when all four digits are 0
- sec_tick  output  1  one-cycle pulse on every decrement

Behaviour:
- Reset: all digits 0, prescaler 0, sec_tick 0, timer_done 1.
- Priority per clk edge: reset > clearn=0 > count > entry.
- Clear (clearn=0): digits 0 and prescaler 0 at the next edge. Overrides enable and digit_valid.
- Entry:
  - Only when enable=0 and digit_valid=1 and digit<=9.
  - Left shift on the edge: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=digit. The old min_tens is discarded.
  - digit>9 is ignored.
  - digit_valid while enable=1 is ignored.
  - sec_tens may hold 6-9 after entry (e.g. 00:90 means 90 s).
- Count:
  - When enable=1 and time != 00:00, the prescaler increments each cycle.
  - On the cycle the prescaler equals TICK_DIV-1: it wraps to 0, the time decrements by one second, and sec_tick=1 for that cycle.
  - With TICK_DIV=N, the first decrement occurs on the Nth enabled cycle.
- Pause: enable=0 freezes the prescaler at its current value. Resuming continues the partial second; the prescaler is not restarted.
- Decrement rules (BCD, one second):
  - sec_units>0: sec_units-1.
  - else sec_tens>0: sec_tens-1, sec_units=9.
  - else: seconds=59 and borrow from minutes.
  - Minute borrow: min_units>0: min_units-1; else min_tens-1, min_units=9.
  - Never decrements below 00:00.
- Zero:
  - The prescaler is forced to 0 on the edge the time reaches 00:00.
  - While the time is 00:00, the prescaler stays 0 and sec_tick stays 0, even with enable held at 1.
- timer_done:
  - Combinational NOR of all digit bits.
  - Goes high in the same cycle the digits read 00:00.
  - Low whenever any digit is nonzero, including while paused.
- sec_tick: registered; high only in the cycle the new decremented value first appears. Its width is always exactly one cycle.
- Outputs are registers except timer_done.
- Reset or clear mid-count behaves as defined above; no partial tick survives.
- Max value 99:99 (entered) counts 99:99, 99:98 … 99:00, 98:59.

Test Plan (TICK_DIV=4):
1. Assert reset 2 cycles -> digits 0000, timer_done=1, sec_tick=0. Then strobe enable=1 for 10 cycles -> no change, no sec_tick.
2. enable=0; strobe digits 1, 3, 0xA, 0 -> digits 01:30, timer_done=0 after the first strobe. Strobing 5,5,5,5,7 -> 55:57.
3. Load 00:02, enable=1 -> 00:01 with sec_tick on the 4th enabled cycle. 00:00 with sec_tick and timer_done=1 on the 8th. Held 20 more cycles -> stays 00:00, no sec_tick.
4. Borrow checks, one tick each:
   - 01:00 -> 00:59
   - 10:00 -> 09:59
   - 00:90 -> 00:89
   - 00:10 -> 00:09
5. Load 00:05:
   - enable=1 for 2 cycles, then 0 for 5 cycles; strobe digit 7 while enable=1 -> ignored.
   - enable=1 again -> decrement to 00:04 on the 2nd resumed cycle.
   - Digit 7 strobed while paused -> shifts in, giving 00:47.
6. Load 12:34, enable=1, count 6 cycles:
   - clearn=0 one cycle -> 00:00 next edge, timer_done=1.
   - Load 00:03, run 3 cycles, assert reset -> 00:00, and the next load-and-run requires the full 4 cycles for the first tick.
